// File: rtl/card_dealer.sv
// card_dealer
// Card source for the blackjack hand/scoring FSM. It models a finite shoe of
// DECKS standard 52-card decks that are drawn without replacement. A
// free-running 16-bit Galois LFSR proposes a candidate rank on every cycle.
// Candidates that are out of range, or whose rank is exhausted, are skipped.
// Each side's card bus holds its value until the next draw for that side.
//
// Ports:
//   clock       system clock, rising edge
//   reset_n     asynchronous active-low reset
//   shuffle     synchronous level, restores the full shoe
//   p_req       player draw request (rising edge detected internally)
//   d_req       dealer draw request (rising edge detected internally)
//   pcard       last player card value, 0..10
//   dcard       last dealer card value, 0..10
//   p_valid     one-cycle pulse when pcard is updated
//   d_valid     one-cycle pulse when dcard is updated
//   busy        high while a draw is in progress
//   cards_left  cards remaining in the shoe
//   deck_empty  high when cards_left == 0
module card_dealer #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          DECKS = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       shuffle,
  input  logic       p_req,
  input  logic       d_req,
  output logic [4:0] pcard,
  output logic [4:0] dcard,
  output logic       p_valid,
  output logic       d_valid,
  output logic       busy,
  output logic [7:0] cards_left,
  output logic       deck_empty
);

  localparam logic [4:0] RANK_FULL = 5'(4 * DECKS);
  localparam logic [7:0] SHOE_FULL = 8'(52 * DECKS);

  typedef enum logic [1:0] {IDLE, DRAW, DONE, EMPTY} state_t;
  typedef enum logic {SIDE_P, SIDE_D} side_t;

  state_t      state_q, state_d;
  side_t       side_q, side_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        p_req_q, p_req_d, d_req_q, d_req_d;
  logic        p_pend_q, p_pend_d, d_pend_q, d_pend_d;
  logic [4:0]  pcard_q, pcard_d, dcard_q, dcard_d;
  logic [7:0]  cards_left_q, cards_left_d;
  logic [4:0]  count_q [13];
  logic [4:0]  count_d [13];

  logic [3:0]  rank;
  logic [4:0]  rank_value;
  logic        rank_hit;
  logic        accept;
  logic        empty_hit;
  logic        finishing;

  assign rank       = lfsr_q[3:0];
  assign rank_value = (rank <= 4'd8) ? ({1'b0, rank} + 5'd1) : 5'd10;

  // rank_hit is set only for a legal rank (0..12) that still has cards left.
  always_comb begin
    rank_hit = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (rank == 4'(i) && count_q[i] != 5'd0) rank_hit = 1'b1;
    end
  end

  assign accept    = (state_q == DRAW) && (cards_left_q != 8'd0) && rank_hit && !shuffle;
  assign empty_hit = (state_q == DRAW) && (cards_left_q == 8'd0) && !shuffle;
  assign finishing = (state_q == DONE) || (state_q == EMPTY);

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      side_q  <= SIDE_P;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
    end
  end

  // FSM next state. The player wins whenever both sides are pending.
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    case (state_q)
      IDLE: begin
        if (p_pend_q) begin
          state_d = DRAW;
          side_d  = SIDE_P;
        end else if (d_pend_q) begin
          state_d = DRAW;
          side_d  = SIDE_D;
        end
      end
      DRAW: begin
        if (cards_left_q == 8'd0) state_d = EMPTY;
        else if (rank_hit)        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      EMPTY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (shuffle) state_d = IDLE;
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q == DRAW);
    p_valid = finishing && (side_q == SIDE_P);
    d_valid = finishing && (side_q == SIDE_D);
  end

  // Datapath next state. An empty shoe loads 0 on the transition into EMPTY,
  // so the card bus already reads 0 while the valid pulse is high.
  // A rise on a side that is already pending is merged into that request.
  always_comb begin
    lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
    p_req_d      = p_req;
    d_req_d      = d_req;
    p_pend_d     = p_pend_q;
    d_pend_d     = d_pend_q;
    pcard_d      = pcard_q;
    dcard_d      = dcard_q;
    cards_left_d = cards_left_q;
    count_d      = count_q;

    if (p_req && !p_req_q) p_pend_d = 1'b1;
    if (d_req && !d_req_q) d_pend_d = 1'b1;
    if (finishing && side_q == SIDE_P) p_pend_d = 1'b0;
    if (finishing && side_q == SIDE_D) d_pend_d = 1'b0;

    if (accept) begin
      for (int i = 0; i < 13; i++) begin
        if (rank == 4'(i)) count_d[i] = count_q[i] - 5'd1;
      end
      cards_left_d = cards_left_q - 8'd1;
      if (side_q == SIDE_P) pcard_d = rank_value;
      else                  dcard_d = rank_value;
    end

    if (empty_hit) begin
      if (side_q == SIDE_P) pcard_d = 5'd0;
      else                  dcard_d = 5'd0;
    end

    if (shuffle) begin
      p_pend_d     = 1'b0;
      d_pend_d     = 1'b0;
      cards_left_d = SHOE_FULL;
      for (int i = 0; i < 13; i++) count_d[i] = RANK_FULL;
    end
  end

  // Datapath registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q       <= SEED;
      p_req_q      <= 1'b0;
      d_req_q      <= 1'b0;
      p_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      pcard_q      <= 5'd0;
      dcard_q      <= 5'd0;
      cards_left_q <= SHOE_FULL;
      for (int i = 0; i < 13; i++) count_q[i] <= RANK_FULL;
    end else begin
      lfsr_q       <= lfsr_d;
      p_req_q      <= p_req_d;
      d_req_q      <= d_req_d;
      p_pend_q     <= p_pend_d;
      d_pend_q     <= d_pend_d;
      pcard_q      <= pcard_d;
      dcard_q      <= dcard_d;
      cards_left_q <= cards_left_d;
      count_q      <= count_d;
    end
  end

  assign pcard      = pcard_q;
  assign dcard      = dcard_q;
  assign cards_left = cards_left_q;
  assign deck_empty = (cards_left_q == 8'd0);

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer
// Scoreboard bench for card_dealer. The stimulus side pushes one expected
// response per issued draw. A negedge monitor pops an entry on every valid
// pulse and checks it against a value-level model of the shoe.
module tb_card_dealer;

  logic       clock;
  logic       reset_n;
  logic       shuffle;
  logic       p_req;
  logic       d_req;
  logic [4:0] pcard;
  logic [4:0] dcard;
  logic       p_valid;
  logic       d_valid;
  logic       busy;
  logic [7:0] cards_left;
  logic       deck_empty;

  card_dealer #(.SEED(16'hACE1), .DECKS(1)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .shuffle    (shuffle),
    .p_req      (p_req),
    .d_req      (d_req),
    .pcard      (pcard),
    .dcard      (dcard),
    .p_valid    (p_valid),
    .d_valid    (d_valid),
    .busy       (busy),
    .cards_left (cards_left),
    .deck_empty (deck_empty)
  );

  typedef struct {
    bit side;
    bit expEmpty;
    int expLeft;
    int issueCyc;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   errors;
  int   cyc;
  int   modelLeft;
  int   valueCount[11];
  int   hist[11];
  int   lastP;
  int   lastD;
  int   runLog[2][5];

  // 100 MHz style clock, with a posedge counter used for latency checks
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Every comparison in the bench goes through here
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Fresh shoe as the model sees it: counts per card value, where the 10, J,
  // Q and K all give value 10
  task automatic resetModel();
    modelLeft = 52;
    valueCount[0] = 0;
    for (int v = 1; v <= 9; v++) valueCount[v] = 4;
    valueCount[10] = 16;
  endtask

  // Raise the requested sides for one cycle and push one expected response
  // per side. The player is pushed first because it has priority.
  task automatic applyStimulus(input bit doP, input bit doD, input int gap);
    exp_t e;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    p_req = doP;
    d_req = doD;
    if (doP) begin
      e.side = 1'b0; e.expEmpty = (modelLeft == 0);
      modelLeft = (modelLeft > 0) ? modelLeft - 1 : 0;
      e.expLeft = modelLeft; e.issueCyc = cyc;
      sbq.push_back(e);
    end
    if (doD) begin
      e.side = 1'b1; e.expEmpty = (modelLeft == 0);
      modelLeft = (modelLeft > 0) ? modelLeft - 1 : 0;
      e.expLeft = modelLeft; e.issueCyc = cyc;
      sbq.push_back(e);
    end
    @(negedge clock);
    p_req = 1'b0;
    d_req = 1'b0;
  endtask

  // Bounded wait for all outstanding draws to be reported
  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", sbq.size(), 0);
      sbq.delete();
    end
  endtask

  // Fixed-timing draw sequence started right after reset release, so that
  // both runs see the same LFSR phase
  task automatic recordRun(input int idx);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 2);
      waitDrain(500);
      runLog[idx][i] = lastP;
    end
  endtask

  task automatic pulseShuffle();
    @(negedge clock);
    shuffle = 1'b1;
    @(negedge clock);
    shuffle = 1'b0;
    resetModel();
  endtask

  // Monitor: each valid pulse must match the head of the scoreboard. A draw
  // must return a value still present in the model shoe; an empty draw must
  // return 0.
  always @(negedge clock) begin : monitor
    exp_t e;
    int   v;
    int   side;
    if (reset_n) begin
      if (p_valid && d_valid) checkOutput("both_valid", 1, 0);
      if (p_valid || d_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          e    = sbq.pop_front();
          side = d_valid ? 1 : 0;
          v    = d_valid ? int'(dcard) : int'(pcard);
          checkOutput("valid_side", side, int'(e.side));
          checkOutput("latency_ge3", int'((cyc - e.issueCyc) >= 3), 1);
          if (e.expEmpty) begin
            checkOutput("empty_card", v, 0);
          end else begin
            checkOutput("card_range", int'(v >= 1 && v <= 10), 1);
            if (v >= 1 && v <= 10) begin
              checkOutput("card_in_shoe", int'(valueCount[v] > 0), 1);
              if (valueCount[v] > 0) valueCount[v]--;
              hist[v]++;
            end
          end
          checkOutput("cards_left", int'(cards_left), e.expLeft);
          if (side == 1) lastD = v;
          else           lastP = v;
        end
      end
    end
  end

  // Main stimulus sequence
  initial begin
    int r;
    int guard;
    int n;
    checks  = 0;
    errors  = 0;
    lastP   = 0;
    lastD   = 0;
    reset_n = 1'b0;
    shuffle = 1'b0;
    p_req   = 1'b0;
    d_req   = 1'b0;
    for (int v = 0; v <= 10; v++) hist[v] = 0;
    resetModel();

    // Reset values
    repeat (2) @(negedge clock);
    checkOutput("rst_pcard", int'(pcard), 0);
    checkOutput("rst_dcard", int'(dcard), 0);
    checkOutput("rst_p_valid", int'(p_valid), 0);
    checkOutput("rst_d_valid", int'(d_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cards_left", int'(cards_left), 52);
    checkOutput("rst_deck_empty", int'(deck_empty), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // First run: five player draws, recorded for the reset-replay check
    recordRun(0);

    // Simultaneous requests: the player is served first
    applyStimulus(1'b1, 1'b1, 1);
    waitDrain(1000);
    checkOutput("busy_after_pair", int'(busy), 0);

    // A second rise while still pending merges into the first request
    @(negedge clock); p_req = 1'b1;
    begin
      exp_t e;
      e.side = 1'b0; e.expEmpty = 1'b0;
      modelLeft--; e.expLeft = modelLeft; e.issueCyc = cyc;
      sbq.push_back(e);
    end
    @(negedge clock); p_req = 1'b0;
    @(negedge clock); p_req = 1'b1;
    @(negedge clock); p_req = 1'b0;
    waitDrain(1000);
    repeat (20) @(negedge clock);

    // Two more random draws, making ten in total, then shuffle
    for (int i = 0; i < 2; i++) begin
      applyStimulus($urandom_range(0, 1) == 0, 1'b0, $urandom_range(0, 3));
      if (p_req == 1'b0 && sbq.size() == 0) applyStimulus(1'b0, 1'b1, 0);
      waitDrain(1000);
    end
    pulseShuffle();
    @(negedge clock);
    checkOutput("shuffle_cards_left", int'(cards_left), 52);
    checkOutput("shuffle_deck_empty", int'(deck_empty), 0);
    checkOutput("shuffle_keeps_pcard", int'(pcard), lastP);
    applyStimulus(1'b1, 1'b0, 1);
    waitDrain(1000);

    // Drain the whole shoe with random sides and gaps, then check the histogram
    pulseShuffle();
    for (int v = 0; v <= 10; v++) hist[v] = 0;
    guard = 0;
    while (modelLeft > 0 && guard < 100) begin
      r = $urandom_range(0, 2);
      if (r == 2 && modelLeft >= 2) applyStimulus(1'b1, 1'b1, $urandom_range(0, 3));
      else if (r == 1)              applyStimulus(1'b0, 1'b1, $urandom_range(0, 3));
      else                          applyStimulus(1'b1, 1'b0, $urandom_range(0, 3));
      waitDrain(3000);
      guard++;
    end
    for (int v = 1; v <= 10; v++) checkOutput($sformatf("hist_%0d", v), hist[v], (v == 10) ? 16 : 4);
    checkOutput("drained_cards_left", int'(cards_left), 0);
    checkOutput("drained_deck_empty", int'(deck_empty), 1);

    // Draw from an empty shoe
    applyStimulus(1'b1, 1'b0, 1);
    waitDrain(100);
    checkOutput("empty_pcard", int'(pcard), 0);
    checkOutput("empty_cards_left", int'(cards_left), 0);

    // Reset in the middle of a draw, then replay the first run
    pulseShuffle();
    applyStimulus(1'b1, 1'b0, 1);
    n = 0;
    while (!busy && n < 50) begin
      @(negedge clock);
      n++;
    end
    checkOutput("busy_seen", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_pcard", int'(pcard), 0);
    checkOutput("midrst_dcard", int'(dcard), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    sbq.delete();
    resetModel();
    repeat (3) begin
      @(negedge clock);
      checkOutput("midrst_no_valid", int'(p_valid | d_valid), 0);
    end
    checkOutput("midrst_cards_left", int'(cards_left), 52);
    @(negedge clock);
    reset_n = 1'b1;
    recordRun(1);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("replay_%0d", i), runLog[1][i], runLog[0][i]);

    repeat (5) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
